fp_round_pipe: RTL and testbench

- Rounding and flag-generation stage directly downstream of the divider.
- Consumes the divider's unrounded result bundle (uround_res_t: u_result, rs, round_en, invalid, exp_cout) plus its divide-by-zero indication.
- Applies the IEEE-754 rounding mode and overflow/underflow handling.
- Emits the final FP word and the 5-bit exception flags through a 2-stage valid/ready pipeline.

---
 rtl/fp_round_pipe_pkg.sv | 104 ++++++++++
 rtl/fp_round_pipe_if.sv | 25 ++
 rtl/fp_round_pipe_core.sv | 64 ++++++
 rtl/fp_round_pipe.sv | 84 ++++++++
 tb/tb_fp_round_pipe.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/fp_round_pipe_pkg.sv
// Shared types for the divider rounding stage.
// Holds the FP format/width helpers, rounding modes, the unrounded bundle,
// the exception-flag struct and small constant/rounding helpers.
package fp_round_pipe_pkg;

    typedef enum logic [1:0] {
        FP32 = 2'd0,
        FP64 = 2'd1,
        FP16 = 2'd2,
        BF16 = 2'd3
    } fp_format_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } roundmode_e;

    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP64:    return 64;
            FP16:    return 16;
            BF16:    return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int unsigned exp_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 11;
            FP16:    return 5;
            BF16:    return 8;
            default: return 8;
        endcase
    endfunction

    function automatic int unsigned man_bits(fp_format_e fmt);
        case (fmt)
            FP64:    return 52;
            FP16:    return 10;
            BF16:    return 7;
            default: return 23;
        endcase
    endfunction

    // Format carried by the divider bundle; bus types are sized from it.
    localparam fp_format_e  PKG_FORMAT = FP32;
    localparam int unsigned FP_WIDTH   = fp_width(PKG_FORMAT);
    localparam int unsigned EXP_WIDTH  = exp_bits(PKG_FORMAT);
    localparam int unsigned MANT_WIDTH = man_bits(PKG_FORMAT);

    typedef struct packed {
        logic                  sign;
        logic [EXP_WIDTH-1:0]  exp;
        logic [MANT_WIDTH-1:0] mant;
    } fp_t;

    typedef struct packed {
        fp_t        u_result;
        logic [1:0] rs;        // {round bit, sticky bit}
        logic       round_en;
        logic       invalid;
        logic [1:0] exp_cout;  // 2'b01 overflow, 2'b1x underflow
    } uround_res_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

    function automatic fp_t max_finite(logic sign);
        fp_t r;
        r.sign   = sign;
        r.exp    = '1;
        r.exp[0] = 1'b0;
        r.mant   = '1;
        return r;
    endfunction

    function automatic fp_t inf_val(logic sign);
        fp_t r;
        r.sign = sign;
        r.exp  = '1;
        r.mant = '0;
        return r;
    endfunction

    // Round-increment decision; unknown encodings behave as RNE.
    function automatic logic round_inc(roundmode_e rnd, logic sign, logic lsb, logic [1:0] rs);
        case (rnd)
            RTZ:     return 1'b0;
            RDN:     return sign & (rs[1] | rs[0]);
            RUP:     return ~sign & (rs[1] | rs[0]);
            RMM:     return rs[1];
            default: return rs[1] & (rs[0] | lsb);
        endcase
    endfunction

endpackage

// File: rtl/fp_round_pipe_if.sv
// Valid/ready bus between the divider, the rounding stage and its consumer.
// slave: rounding stage side; master: producer/consumer side.
interface fp_round_pipe_if;
    import fp_round_pipe_pkg::*;

    logic                valid_i;
    logic                ready_o;
    uround_res_t         urnd_result_i;
    logic                divide_by_zero_i;
    roundmode_e          rnd_i;
    logic                valid_o;
    logic                ready_i;
    logic [FP_WIDTH-1:0] result_o;
    fflags_t             fflags_o;

    modport slave (
        input  valid_i, urnd_result_i, divide_by_zero_i, rnd_i, ready_i,
        output ready_o, valid_o, result_o, fflags_o
    );

    modport master (
        output valid_i, urnd_result_i, divide_by_zero_i, rnd_i, ready_i,
        input  ready_o, valid_o, result_o, fflags_o
    );
endinterface

// File: rtl/fp_round_pipe_core.sv
// fp_round_core: combinational rounding add plus overflow/underflow select.
// Ports: urnd_res (bundle), dz (divide-by-zero), rnd (mode), inc (round-up
// decision from stage 1) -> result_c (final word), fflags_c (exception flags).
module fp_round_core
    import fp_round_pipe_pkg::*;
(
    input  uround_res_t urnd_res,
    input  logic        dz,
    input  roundmode_e  rnd,
    input  logic        inc,
    output fp_t         result_c,
    output fflags_t     fflags_c
);
    localparam int unsigned MAG_W = EXP_WIDTH + MANT_WIDTH;

    logic                 sign;
    logic [MAG_W-1:0]     mag;
    logic [MAG_W-1:0]     mag_rnd;
    logic [EXP_WIDTH-1:0] exp_rnd;
    logic                 inexact;
    logic                 nonzero;
    logic                 overflow;
    logic                 underflow;

    // Mantissa carry ripples into the exponent through a single add.
    always_comb begin
        sign      = urnd_res.u_result.sign;
        mag       = {urnd_res.u_result.exp, urnd_res.u_result.mant};
        mag_rnd   = mag + MAG_W'(inc);
        exp_rnd   = mag_rnd[MAG_W-1 -: EXP_WIDTH];
        inexact   = |urnd_res.rs;
        nonzero   = (|mag) | inexact;
        overflow  = (urnd_res.exp_cout == 2'b01) | (~urnd_res.exp_cout[1] & (&exp_rnd));
        underflow = urnd_res.exp_cout[1] | ((exp_rnd == '0) & nonzero);
    end

    // Result/flag select; NV and DZ always pass through.
    always_comb begin
        result_c    = urnd_res.u_result;
        fflags_c    = '0;
        fflags_c.nv = urnd_res.invalid;
        fflags_c.dz = dz;
        if (urnd_res.round_en) begin
            result_c = fp_t'({sign, mag_rnd});
            if (overflow) begin
                case (rnd)
                    RTZ:     result_c = max_finite(sign);
                    RDN:     result_c = sign ? inf_val(1'b1) : max_finite(1'b0);
                    RUP:     result_c = sign ? max_finite(1'b1) : inf_val(1'b0);
                    default: result_c = inf_val(sign);
                endcase
                fflags_c.of = 1'b1;
                fflags_c.nx = 1'b1;
            end else if (underflow) begin
                result_c      = '0;
                result_c.sign = sign;
                fflags_c.uf   = 1'b1;
                fflags_c.nx   = 1'b1;
            end else begin
                fflags_c.nx = inexact;
            end
        end
    end
endmodule

// File: rtl/fp_round_pipe.sv
// fp_round_pipe: 2-stage valid/ready rounding and flag stage after the divider.
// Ports: clk_i, reset_i (async active-low), io (slave side of fp_round_pipe_if:
// valid_i/ready_o/urnd_result_i/divide_by_zero_i/rnd_i in, valid_o/ready_i/
// result_o/fflags_o out).
module fp_round_pipe
    import fp_round_pipe_pkg::*;
#(
    parameter fp_format_e FP_FORMAT = FP32
) (
    input  logic          clk_i,
    input  logic          reset_i,
    fp_round_pipe_if.slave io
);
    localparam int unsigned FP_W = fp_width(FP_FORMAT);

    logic            s1_valid;
    uround_res_t     s1_res;
    logic            s1_dz;
    roundmode_e      s1_rnd;
    logic            s1_inc;

    logic            s2_valid;
    logic [FP_W-1:0] s2_result;
    fflags_t         s2_fflags;

    logic            s1_en;
    logic            s2_en;
    fp_t             core_result;
    fflags_t         core_fflags;

    // Each stage advances when empty or when its successor is advancing.
    assign s2_en      = ~s2_valid | io.ready_i;
    assign s1_en      = ~s1_valid | s2_en;
    assign io.ready_o = s1_en;

    // Stage 1: capture bundle and mode, decide the round increment.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            s1_valid <= 1'b0;
            s1_res   <= '0;
            s1_dz    <= 1'b0;
            s1_rnd   <= RNE;
            s1_inc   <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= io.valid_i;
            if (io.valid_i) begin
                s1_res <= io.urnd_result_i;
                s1_dz  <= io.divide_by_zero_i;
                s1_rnd <= io.rnd_i;
                s1_inc <= round_inc(io.rnd_i, io.urnd_result_i.u_result.sign,
                                    io.urnd_result_i.u_result.mant[0],
                                    io.urnd_result_i.rs);
            end
        end
    end

    fp_round_core u_core (
        .urnd_res (s1_res),
        .dz       (s1_dz),
        .rnd      (s1_rnd),
        .inc      (s1_inc),
        .result_c (core_result),
        .fflags_c (core_fflags)
    );

    // Stage 2: hold the rounded word and flags until the consumer takes them.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_fflags <= '0;
        end else if (s2_en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_result <= FP_W'(core_result);
                s2_fflags <= core_fflags;
            end
        end
    end

    assign io.valid_o  = s2_valid;
    assign io.result_o = s2_result;
    assign io.fflags_o = s2_fflags;
endmodule

// File: tb/tb_fp_round_pipe.sv
// Directed bench for fp_round_pipe: vector table plus backpressure, throughput
// and mid-flight reset sequences.
module tb_fp_round_pipe;
    import fp_round_pipe_pkg::*;

    typedef struct {
        string      name;
        logic [31:0] u;
        logic [1:0]  rs;
        logic        en;
        logic        inv;
        logic [1:0]  ec;
        logic        dz;
        roundmode_e  rnd;
        logic [31:0] res;
        logic [4:0]  fl;
    } vec_t;

    localparam int NV = 22;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    vec_t tv [NV];

    fp_round_pipe_if bus ();

    fp_round_pipe #(.FP_FORMAT(FP32)) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .io      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(string nm, logic [31:0] u, logic [1:0] rs, logic en,
                                logic inv, logic [1:0] ec, logic dz, roundmode_e rnd,
                                logic [31:0] res, logic [4:0] fl);
        vec_t v;
        v.name = nm; v.u = u; v.rs = rs; v.en = en; v.inv = inv; v.ec = ec;
        v.dz = dz; v.rnd = rnd; v.res = res; v.fl = fl;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.valid_i                      = 1'b1;
        bus.urnd_result_i.u_result       = fp_t'(v.u);
        bus.urnd_result_i.rs             = v.rs;
        bus.urnd_result_i.round_en       = v.en;
        bus.urnd_result_i.invalid        = v.inv;
        bus.urnd_result_i.exp_cout       = v.ec;
        bus.divide_by_zero_i             = v.dz;
        bus.rnd_i                        = v.rnd;
    endtask

    task automatic check_out(input string tag, input vec_t v);
        check({v.name, tag, "_valid"}, 32'(bus.valid_o), 32'd1);
        check({v.name, tag, "_result"}, bus.result_o, v.res);
        check({v.name, tag, "_fflags"}, 32'(bus.fflags_o), 32'(v.fl));
    endtask

    // Accept on one edge, stage 2 loads on the next.
    task automatic run_vec(input vec_t v);
        drive(v);
        check({v.name, "_ready"}, 32'(bus.ready_o), 32'd1);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        check({v.name, "_lat1"}, 32'(bus.valid_o), 32'd0);
        @(posedge clk); #1;
        check_out("", v);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        tv[0]  = mk("third_rne",   32'h3EAAAAAA, 2'b11, 1, 0, 2'b00, 0, RNE, 32'h3EAAAAAB, 5'h01);
        tv[1]  = mk("third_rtz",   32'h3EAAAAAA, 2'b11, 1, 0, 2'b00, 0, RTZ, 32'h3EAAAAAA, 5'h01);
        tv[2]  = mk("ovf_rne",     32'h7F7FFFFF, 2'b10, 1, 0, 2'b00, 0, RNE, 32'h7F800000, 5'h05);
        tv[3]  = mk("ovf_rtz",     32'h7F7FFFFF, 2'b10, 1, 0, 2'b00, 0, RTZ, 32'h7F7FFFFF, 5'h01);
        tv[4]  = mk("ovf_rup_neg", 32'hFF7FFFFF, 2'b10, 1, 0, 2'b01, 0, RUP, 32'hFF7FFFFF, 5'h05);
        tv[5]  = mk("ovf_rdn_neg", 32'hFF7FFFFF, 2'b10, 1, 0, 2'b01, 0, RDN, 32'hFF800000, 5'h05);
        tv[6]  = mk("ovf_rdn_pos", 32'h7F7FFFFF, 2'b10, 1, 0, 2'b01, 0, RDN, 32'h7F7FFFFF, 5'h05);
        tv[7]  = mk("ovf_rmm",     32'h7F7FFFFF, 2'b10, 1, 0, 2'b00, 0, RMM, 32'h7F800000, 5'h05);
        tv[8]  = mk("pass_dz",     32'hFF800000, 2'b00, 0, 0, 2'b00, 1, RNE, 32'hFF800000, 5'h08);
        tv[9]  = mk("pass_nv",     32'h7FC00000, 2'b00, 0, 1, 2'b00, 0, RNE, 32'h7FC00000, 5'h10);
        tv[10] = mk("exact_rdn",   32'h40400000, 2'b00, 1, 0, 2'b00, 0, RDN, 32'h40400000, 5'h00);
        tv[11] = mk("exact_rmm",   32'h40400000, 2'b00, 1, 0, 2'b00, 0, RMM, 32'h40400000, 5'h00);
        tv[12] = mk("tie_even",    32'h3F800000, 2'b10, 1, 0, 2'b00, 0, RNE, 32'h3F800000, 5'h01);
        tv[13] = mk("tie_rmm",     32'h3F800000, 2'b10, 1, 0, 2'b00, 0, RMM, 32'h3F800001, 5'h01);
        tv[14] = mk("rup_carry",   32'h3FFFFFFF, 2'b01, 1, 0, 2'b00, 0, RUP, 32'h40000000, 5'h01);
        tv[15] = mk("rdn_neg",     32'hBF800000, 2'b01, 1, 0, 2'b00, 0, RDN, 32'hBF800001, 5'h01);
        tv[16] = mk("unf_cout",    32'h80400000, 2'b01, 1, 0, 2'b10, 0, RNE, 32'h80000000, 5'h03);
        tv[17] = mk("unf_zexp",    32'h00000001, 2'b00, 1, 0, 2'b00, 0, RNE, 32'h00000000, 5'h03);
        tv[18] = mk("nv_rounded",  32'h40400000, 2'b00, 1, 1, 2'b00, 0, RNE, 32'h40400000, 5'h10);
        tv[19] = mk("bad_mode",    32'h3EAAAAAA, 2'b11, 1, 0, 2'b00, 0, roundmode_e'(3'b101),
                    32'h3EAAAAAB, 5'h01);
        tv[20] = mk("pass_inexact",32'h3EAAAAAA, 2'b11, 0, 0, 2'b00, 0, RNE, 32'h3EAAAAAA, 5'h00);
        tv[21] = mk("zero_exact",  32'h00000000, 2'b00, 1, 0, 2'b00, 0, RNE, 32'h00000000, 5'h00);

        rst_n                = 1'b0;
        bus.valid_i          = 1'b0;
        bus.ready_i          = 1'b1;
        bus.urnd_result_i    = '0;
        bus.divide_by_zero_i = 1'b0;
        bus.rnd_i            = RNE;

        #2;
        check("rst_valid",  32'(bus.valid_o), 32'd0);
        check("rst_result", bus.result_o, 32'd0);
        check("rst_fflags", 32'(bus.fflags_o), 32'd0);
        check("rst_ready",  32'(bus.ready_o), 32'd1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) run_vec(tv[i]);

        // Back-to-back with ready_i high: one result per cycle.
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(tv[i]);
            else       bus.valid_i = 1'b0;
            @(posedge clk); #1;
            if (i >= 1) check_out("_b2b", tv[i-1]);
        end
        @(posedge clk); #1;
        check("b2b_drain", 32'(bus.valid_o), 32'd0);

        // Backpressure: A, B accepted, C stalls at the input.
        bus.ready_i = 1'b0;
        drive(tv[0]);
        @(posedge clk); #1;
        drive(tv[2]);
        check("bp_ready_b", 32'(bus.ready_o), 32'd1);
        @(posedge clk); #1;
        drive(tv[8]);
        check("bp_ready_c0", 32'(bus.ready_o), 32'd0);
        @(posedge clk); #1;
        check("bp_ready_c1", 32'(bus.ready_o), 32'd0);
        check_out("_hold1", tv[0]);
        @(posedge clk); #1;
        check_out("_hold2", tv[0]);
        bus.ready_i = 1'b1;
        #1;
        check("bp_ready_rel", 32'(bus.ready_o), 32'd1);
        check_out("_bpA", tv[0]);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        check_out("_bpB", tv[2]);
        @(posedge clk); #1;
        check_out("_bpC", tv[8]);
        @(posedge clk); #1;
        check("bp_drain", 32'(bus.valid_o), 32'd0);

        // Reset with both stages full: outputs clear without a clock edge.
        bus.ready_i = 1'b0;
        drive(tv[0]);
        @(posedge clk); #1;
        drive(tv[2]);
        @(posedge clk); #1;
        bus.valid_i = 1'b0;
        check("mid_full", 32'(bus.valid_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid",  32'(bus.valid_o), 32'd0);
        check("mid_rst_result", bus.result_o, 32'd0);
        check("mid_rst_fflags", 32'(bus.fflags_o), 32'd0);
        bus.ready_i = 1'b1;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_empty", 32'(bus.valid_o), 32'd0);
        run_vec(tv[10]);
        @(posedge clk); #1;
        check("post_rst_drain", 32'(bus.valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
